// File: rtl/nos_pkg.sv
// Shared constants, request record and address helpers for the digit-sprite
// palette ROM (10 glyphs of 12x18 pixels, 24-bit RGB).
package nos_pkg;

    localparam int NOS_W      = 12;
    localparam int NOS_H      = 18;
    localparam int NOS_DIGITS = 10;
    localparam int NOS_DEPTH  = 2160;
    localparam int NOS_ADDR_W = 12;
    localparam logic [23:0] NOS_TRANSPARENT = 24'hFF0000;

    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] px;
        logic [4:0] py;
    } nos_req_t;

    // digit*216 + py*12 + px with shift-add multipliers (216 = 128+64+16+8, 12 = 8+4)
    function automatic logic [NOS_ADDR_W-1:0] nos_addr(input nos_req_t r);
        logic [NOS_ADDR_W-1:0] d;
        logic [NOS_ADDR_W-1:0] y;
        logic [NOS_ADDR_W-1:0] x;
        d = {8'd0, r.digit};
        y = {7'd0, r.py};
        x = {8'd0, r.px};
        return (d << 7) + (d << 6) + (d << 4) + (d << 3) + (y << 3) + (y << 2) + x;
    endfunction

    function automatic logic nos_range_err(input nos_req_t r);
        return (r.digit > 4'd9) || (r.px > 4'd11) || (r.py > 5'd17);
    endfunction

endpackage

// File: rtl/rom_nos.sv
// Stand-in for the digit palette ROM: one-cycle registered read whose colour
// is a fixed function of the address so each entry is distinguishable.
module rom_nos (
    input  logic        Clk,
    input  logic [11:0] read_address,
    output logic [23:0] data_out
);

    // Registered read port
    always_ff @(posedge Clk) begin
        data_out <= {read_address, read_address ^ 12'hA5C};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from rr_ptr,
// pointer advances past the winner and holds when nobody requests.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Search for the first active request at or after the pointer, wrapping
    always_comb begin
        int j;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!found_s && req_i[j]) begin
                found_s = 1'b1;
                idx_s   = IDX_W'(j);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grants are suppressed while reset is held; pointer moves past the winner
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = found_s && rst_ni;
        gnt_idx_o   = idx_s;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_valid_o) begin
            gnt_o    = {{(N-1){1'b0}}, 1'b1} << idx_s;
            rr_ptr_d = (idx_s == IDX_W'(N - 1)) ? '0 : idx_s + 1'b1;
        end else begin
            gnt_o    = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/nos_fetch_arbiter.sv
// Shares the digit palette ROM between several number renderers: round-robin
// grant, address formation with range check, and a fixed 2-cycle response pipe.
module nos_fetch_arbiter
    import nos_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0][3:0]     req_digit,
    input  logic [NUM_REQ-1:0][3:0]     req_px,
    input  logic [NUM_REQ-1:0][4:0]     req_py,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NOS_ADDR_W-1:0]       rom_read_address,
    input  logic [23:0]                 rom_data_out,
    output logic                        resp_valid,
    output logic [ID_W-1:0]             resp_id,
    output logic                        resp_err,
    output logic [23:0]                 resp_rgb
);

    logic [ID_W-1:0]       gnt_idx_s;
    logic                  gnt_valid_s;
    nos_req_t              sel_s;
    logic                  sel_err_s;
    logic [NOS_ADDR_W-1:0] addr_d;

    logic [NOS_ADDR_W-1:0] addr_q;
    logic                  s1_valid_q;
    logic [ID_W-1:0]       s1_id_q;
    logic                  s1_err_q;
    logic                  s2_valid_q;
    logic [ID_W-1:0]       s2_id_q;
    logic                  s2_err_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Pick the winner's fields and form its address; bad fields read entry 0
    always_comb begin
        sel_s.digit = req_digit[gnt_idx_s];
        sel_s.px    = req_px[gnt_idx_s];
        sel_s.py    = req_py[gnt_idx_s];
        sel_err_s   = nos_range_err(sel_s);
        if (sel_err_s) begin
            addr_d = '0;
        end else begin
            addr_d = nos_addr(sel_s);
        end
    end

    // S1: address register holds across idle cycles, valid only on a grant
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= gnt_valid_s;
            if (gnt_valid_s) begin
                addr_q   <= addr_d;
                s1_id_q  <= gnt_idx_s;
                s1_err_q <= sel_err_s;
            end
        end
    end

    // S2: aligned with the ROM's internal data register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_err_q   <= s1_err_q;
        end
    end

    // Response mux: errored requests return the transparent key colour
    always_comb begin
        rom_read_address = addr_q;
        resp_valid       = s2_valid_q;
        resp_id          = s2_id_q;
        resp_err         = s2_err_q;
        if (s2_err_q) begin
            resp_rgb = NOS_TRANSPARENT;
        end else begin
            resp_rgb = rom_data_out;
        end
    end

endmodule

// File: tb/tb_nos_fetch_arbiter.sv
// Directed self-checking bench for nos_fetch_arbiter with the palette ROM
// attached; expected values are hand-computed addresses and ROM colours.
module tb_nos_fetch_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                    Clk;
    logic                    Reset_n;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0][3:0] req_digit;
    logic [NUM_REQ-1:0][3:0] req_px;
    logic [NUM_REQ-1:0][4:0] req_py;
    logic [NUM_REQ-1:0]      gnt;
    logic [11:0]             rom_read_address;
    logic [23:0]             rom_data_out;
    logic                    resp_valid;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_err;
    logic [23:0]             resp_rgb;

    int n_vec;
    int n_mis;

    nos_fetch_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .req              (req),
        .req_digit        (req_digit),
        .req_px           (req_px),
        .req_py           (req_py),
        .gnt              (gnt),
        .rom_read_address (rom_read_address),
        .rom_data_out     (rom_data_out),
        .resp_valid       (resp_valid),
        .resp_id          (resp_id),
        .resp_err         (resp_err),
        .resp_rgb         (resp_rgb)
    );

    rom_nos u_rom (
        .Clk          (Clk),
        .read_address (rom_read_address),
        .data_out     (rom_data_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [23:0] rom_color(input logic [11:0] a);
        return {a, a ^ 12'hA5C};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_fields(input int i, input logic [3:0] d, input logic [3:0] x, input logic [4:0] y);
        req_digit[i] = d;
        req_px[i]    = x;
        req_py[i]    = y;
    endtask

    initial begin
        logic [11:0] rot_addr [4];
        n_vec     = 0;
        n_mis     = 0;
        Reset_n   = 1'b0;
        req       = 4'hF;
        req_digit = '0;
        req_px    = '0;
        req_py    = '0;
        for (int i = 0; i < NUM_REQ; i++) set_fields(i, 4'(i), 4'(i), 5'(i));

        // reset held with all requesting
        cyc(); cyc(); settle();
        check_vec("rst_gnt",   32'(gnt), 32'h0);
        check_vec("rst_valid", 32'(resp_valid), 32'h0);
        check_vec("rst_addr",  32'(rom_read_address), 32'h0);
        Reset_n = 1'b1;
        settle();
        check_vec("rst_first_gnt", 32'(gnt), 32'h1);
        cyc();
        req = 4'h0;
        cyc(); cyc(); cyc();

        // single request from requester 2 (ptr now 1)
        set_fields(2, 4'd7, 4'd5, 5'd10);
        req = 4'b0100;
        settle();
        check_vec("single_gnt", 32'(gnt), 32'h4);
        cyc();
        req = 4'h0;
        settle();
        check_vec("single_addr", 32'(rom_read_address), 32'd1637);
        check_vec("single_gnt_idle", 32'(gnt), 32'h0);
        cyc(); settle();
        check_vec("single_valid", 32'(resp_valid), 32'h1);
        check_vec("single_id",    32'(resp_id), 32'd2);
        check_vec("single_err",   32'(resp_err), 32'h0);
        check_vec("single_rgb",   32'(resp_rgb), 32'(rom_color(12'd1637)));
        cyc(); settle();
        check_vec("single_done", 32'(resp_valid), 32'h0);
        check_vec("addr_hold",   32'(rom_read_address), 32'd1637);

        // reset one cycle after a grant drops the in-flight request
        req = 4'b0100;
        settle();
        check_vec("mid_gnt", 32'(gnt), 32'h4);
        cyc();
        req = 4'h0;
        Reset_n = 1'b0;
        settle();
        check_vec("mid_addr",  32'(rom_read_address), 32'h0);
        check_vec("mid_valid", 32'(resp_valid), 32'h0);
        cyc();
        Reset_n = 1'b1;
        settle();
        check_vec("mid_noresp1", 32'(resp_valid), 32'h0);
        cyc(); settle();
        check_vec("mid_noresp2", 32'(resp_valid), 32'h0);

        // rotation: all four requesting for 8 cycles, pointer back at 0
        for (int i = 0; i < NUM_REQ; i++) begin
            set_fields(i, 4'(i), 4'(i), 5'(i));
            rot_addr[i] = 12'(229 * i);
        end
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'hF : 4'h0;
            settle();
            if (k < 8) check_vec($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            if (k >= 1 && k <= 8)
                check_vec($sformatf("rot_addr%0d", k), 32'(rom_read_address), 32'(rot_addr[(k - 1) % 4]));
            if (k >= 2) begin
                check_vec($sformatf("rot_valid%0d", k), 32'(resp_valid), 32'h1);
                check_vec($sformatf("rot_id%0d", k),    32'(resp_id), 32'((k - 2) % 4));
                check_vec($sformatf("rot_rgb%0d", k),   32'(resp_rgb), 32'(rom_color(rot_addr[(k - 2) % 4])));
            end
            cyc();
        end
        req = 4'h0;
        cyc(); cyc();

        // bounds: maximum address then digit out of range (ptr at 0)
        set_fields(0, 4'd9, 4'd11, 5'd17);
        set_fields(3, 4'd12, 4'd0, 5'd0);
        req = 4'b0001;
        settle();
        check_vec("max_gnt", 32'(gnt), 32'h1);
        cyc();
        req = 4'b1000;
        settle();
        check_vec("err_gnt",  32'(gnt), 32'h8);
        check_vec("max_addr", 32'(rom_read_address), 32'd2159);
        cyc();
        req = 4'h0;
        settle();
        check_vec("err_addr",  32'(rom_read_address), 32'h0);
        check_vec("max_valid", 32'(resp_valid), 32'h1);
        check_vec("max_err",   32'(resp_err), 32'h0);
        check_vec("max_rgb",   32'(resp_rgb), 32'(rom_color(12'd2159)));
        cyc(); settle();
        check_vec("err_valid", 32'(resp_valid), 32'h1);
        check_vec("err_id",    32'(resp_id), 32'd3);
        check_vec("err_flag",  32'(resp_err), 32'h1);
        check_vec("err_rgb",   32'(resp_rgb), 32'hFF0000);
        cyc();

        // sole requester 1 held for 3 cycles: granted back to back
        set_fields(1, 4'd3, 4'd2, 5'd4);
        for (int k = 0; k < 5; k++) begin
            req = (k < 3) ? 4'b0010 : 4'b0000;
            settle();
            if (k < 3) check_vec($sformatf("sole_gnt%0d", k), 32'(gnt), 32'h2);
            if (k >= 2) begin
                check_vec($sformatf("sole_valid%0d", k), 32'(resp_valid), 32'h1);
                check_vec($sformatf("sole_id%0d", k),    32'(resp_id), 32'd1);
                check_vec($sformatf("sole_rgb%0d", k),   32'(resp_rgb), 32'(rom_color(12'd698)));
            end
            cyc();
        end
        settle();
        check_vec("sole_done", 32'(resp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/nos_fetch_arbiter.md
# nos_fetch_arbiter

Shares the single digit-sprite palette ROM (`rom_nos`: 10 digits of 12x18 pixels, 2160 entries, one-cycle registered read, 24-bit RGB out) between several on-screen number renderers (score, speed, timer, lap). Each requester asks for one pixel of one digit glyph. The block arbitrates round-robin, forms the ROM address, tracks the ROM read latency, and returns the RGB value tagged with the requester ID. It sits between the per-display renderers and the ROM instance inside the color mapper.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, `$clog2(NUM_REQ)`: width of the response ID.

Ports:
- `Clk` in 1: system clock. Single clock domain.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester request. Held high until granted.
- `req_digit` in NUM_REQ x 4: glyph index, valid 0..9.
- `req_px` in NUM_REQ x 4: pixel column, valid 0..11.
- `req_py` in NUM_REQ x 5: pixel row, valid 0..17.
- `gnt` out NUM_REQ: one-hot, one-cycle grant pulse.
- `rom_read_address` out 12: drives the ROM `read_address`. Registered.
- `rom_data_out` in 24: the ROM `data_out`.
- `resp_valid` out 1: response strobe.
- `resp_id` out ID_W: index of the requester being answered.
- `resp_err` out 1: the request had an out-of-range field.
- `resp_rgb` out 24: pixel color.

## Operation
- **Arbitration.** Combinational round-robin over `req`, starting at pointer `rr_ptr`.
  - At most one `gnt` bit is high per cycle.
  - `gnt` is high in the same cycle the winning `req` is sampled.
  - After a grant to index k, `rr_ptr` becomes (k+1) mod NUM_REQ.
  - With no requests, `rr_ptr` holds its value.
- **Requester rule.** A requester may change its fields or drop `req` only after the cycle in which it sees `gnt`. Dropping `req` before the grant is legal: the request is simply withdrawn.
- **Address formation.**
  - `addr = digit*216 + py*12 + px`, computed 12 bits wide, maximum 2159.
  - Multiplies are built from shifts and adds: 216 = 128+64+16+8, 12 = 8+4.
- **Range check.** The request is in error if `digit > 9`, `px > 11` or `py > 17`.
  - On error, `rom_read_address` is loaded with 0 and `err` is carried down the pipe.
  - Response is `resp_err=1`, `resp_rgb=24'hFF0000` (the transparent key).
- **Pipeline.**
  - S1 (registered on grant): `rom_read_address`, `s1_valid`, `s1_id`, `s1_err`.
  - S2: `s2_valid`, `s2_id`, `s2_err`. The ROM's internal data register is aligned with this stage.
  - Outputs are combinational from S2 and the ROM: `resp_valid = s2_valid`, `resp_id = s2_id`, `resp_rgb = s2_err ? 24'hFF0000 : rom_data_out`.
- **Throughput.** One grant per cycle, fully pipelined, no stalls or backpressure. Requesters must accept a response in the cycle it appears.
- **Address hold.** When no grant occurs, `rom_read_address` keeps its previous value and `s1_valid` is 0.

## Timing
- Grant at cycle t, address at t+1, `resp_valid` at t+2. Latency is fixed at 2 cycles.
- **Reset.** Assertion of `Reset_n` low takes effect immediately, without waiting for a clock edge:
  - `rr_ptr` = 0, `rom_read_address` = 0, `s1_valid`/`s2_valid` = 0, `s1_id`/`s2_id` = 0, `s1_err`/`s2_err` = 0.
  - `resp_valid` = 0 and `gnt` = 0 while reset is held.
- **Reset mid-operation.** In-flight requests are dropped with no response. Requesters re-issue after reset.
- **Simultaneous requests.** Lowest index at or after `rr_ptr` wins.
  - With all four requesting continuously, grants rotate 0,1,2,3,0,…
- **Back-to-back grants.** A requester holding `req` through its grant cycle is not re-granted in the next cycle while others are waiting. It is re-granted in the next cycle only if it is the sole requester.

## Structure
- Package `nos_pkg` holds:
  - Constants `NOS_W=12`, `NOS_H=18`, `NOS_DIGITS=10`, `NOS_DEPTH=2160`, `NOS_ADDR_W=12`, `NOS_TRANSPARENT=24'hFF0000`.
  - A typedef `nos_req_t` of {digit, px, py}.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, output one-hot `gnt`, owns `rr_ptr`, async active-low reset.
- The top module does address formation, the range check, the S1/S2 registers and the output mux.
- The ROM is instantiated outside this block. The testbench instantiates `rom_nos` next to the DUT.

## Test plan
- **Reset.** Hold `Reset_n`=0 with all `req` high. Expect `gnt`=0, `resp_valid`=0, `rom_read_address`=0. Release: the first grant goes to index 0.
- **Single request.** Requester 2 asks for digit 7, px 5, py 10. Expect `gnt[2]` at t, `rom_read_address`=1637 at t+1, and at t+2 `resp_valid`=1, `resp_id`=2, `resp_rgb` equal to the ROM entry 1637 color.
- **Rotation.** All four requesters hold `req` for 8 cycles. Expect grants 0,1,2,3,0,1,2,3, one per cycle, and responses in the same order 2 cycles later.
- **Bounds.** Maximum address: digit 9, px 11, py 17 gives `rom_read_address`=2159. Out of range: digit 12 gives `resp_err`=1 and `resp_rgb`=FF0000, with `rom_read_address`=0.
- **Reset mid-stream.** Assert `Reset_n` low one cycle after a grant. Expect no `resp_valid` for that request and `rr_ptr` back at 0.
- **Sole requester.** Requester 1 alone, holding `req` for 3 cycles. Expect `gnt[1]` in 3 consecutive cycles and 3 consecutive responses.
